veri_phase_comp_coarse_accum: RTL and testbench

Parametrised coarse-phase accumulator for the phase comparator's high path. It generalises the 2-bit coarse register to WIDTH bits. It takes up/down step pulses from the fine path and applies each one modulo 2^WIDTH, then enforces a settling blank window after every phase change. It supports a synchronous load and reports wrap events and blanking status to the loop controller.

---
 rtl/veri_phase_comp_pkg.sv | 24 ++
 rtl/veri_phase_comp_blank_cnt.sv | 30 +++
 rtl/veri_phase_comp_coarse_accum.sv | 102 ++++++++++
 tb/tb_veri_phase_comp_coarse_accum.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/veri_phase_comp_pkg.sv
// Shared types and helpers for the coarse-phase accumulator.
package veri_phase_comp_pkg;

  typedef enum logic {IDLE, BLANK} state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN} step_t;

  // Blank counter width: clog2 of the window length, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BLANK_CNT_W = cnt_width(4);

  // Exactly one request line high is a step; anything else is a no-op.
  function automatic step_t decode_step(input logic up, input logic dn);
    case ({up, dn})
      2'b10:   return STEP_UP;
      2'b01:   return STEP_DN;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/veri_phase_comp_blank_cnt.sv
// Loadable down-counter timing the post-step settling window.
module veri_phase_comp_blank_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/veri_phase_comp_coarse_accum.sv
// Coarse-phase accumulator: modulo up/down stepping with a settling blank window.
// Define COARSE_ACCUM_SAT_EN to saturate at the code limits instead of wrapping.
module veri_phase_comp_coarse_accum
  import veri_phase_comp_pkg::*;
#(
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned RESET_VAL    = 1,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enable,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             step_up,
  input  logic             step_dn,
  output logic [WIDTH-1:0] reg_out,
  output logic             busy,
  output logic             wrap,
  output logic             dropped
);

  localparam int unsigned CNT_W    = cnt_width(BLANK_CYCLES);
  localparam logic [WIDTH-1:0] MAX_CODE = {WIDTH{1'b1}};
  localparam bit          ONE_BIT  = (WIDTH == 1);

  state_t state;
  step_t  step_c;
  logic   step_valid_c;
  logic   step_wraps_c;
  logic   sat_block_c;
  logic   accept_c;
  logic   cnt_clear_c;
  logic   cnt_dec_c;
  logic   cnt_zero_c;
  logic   wrap_next_c;

  assign step_c       = decode_step(step_up, step_dn);
  assign step_valid_c = (step_c != STEP_NONE);
  assign step_wraps_c = ((step_c == STEP_UP) && (reg_out == MAX_CODE)) ||
                        ((step_c == STEP_DN) && (reg_out == '0));

`ifdef COARSE_ACCUM_SAT_EN
  // A step past either limit is absorbed: no move, no blank, no wrap.
  assign sat_block_c = step_wraps_c;
  assign wrap_next_c = 1'b0;
`else
  assign sat_block_c = 1'b0;
  assign wrap_next_c = step_wraps_c || ONE_BIT;
`endif

  assign accept_c    = enable && !load_en && (state == IDLE) && step_valid_c && !sat_block_c;
  assign cnt_clear_c = enable && load_en;
  assign cnt_dec_c   = enable && !load_en && (state == BLANK) && !cnt_zero_c;

  veri_phase_comp_blank_cnt #(
    .CNT_W(CNT_W)
  ) u_blank_cnt (
    .clk     (clk),
    .resetb  (resetb),
    .clear   (cnt_clear_c),
    .load    (accept_c),
    .load_val(CNT_W'(BLANK_CYCLES - 1)),
    .dec     (cnt_dec_c),
    .zero_c  (cnt_zero_c)
  );

  // Phase register, blank FSM and event pulses.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      reg_out <= WIDTH'(RESET_VAL);
      busy    <= 1'b0;
      wrap    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      wrap    <= 1'b0;
      dropped <= 1'b0;
      if (enable) begin
        if (load_en) begin
          reg_out <= load_data;
          state   <= IDLE;
          busy    <= 1'b0;
        end else if (state == IDLE) begin
          if (accept_c) begin
            reg_out <= (step_c == STEP_UP) ? reg_out + WIDTH'(1) : reg_out - WIDTH'(1);
            state   <= BLANK;
            busy    <= 1'b1;
            wrap    <= wrap_next_c;
          end
        end else begin
          dropped <= step_valid_c;
          if (cnt_zero_c) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_veri_phase_comp_coarse_accum.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_veri_phase_comp_coarse_accum;

  localparam int unsigned WIDTH        = 2;
  localparam int unsigned RESET_VAL    = 1;
  localparam int unsigned BLANK_CYCLES = 4;
  localparam int          MAXV         = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic             enable = 1'b0;
  logic             load_en = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             step_up = 1'b0;
  logic             step_dn = 1'b0;
  logic [WIDTH-1:0] reg_out;
  logic             busy;
  logic             wrap;
  logic             dropped;

  int checks = 0;
  int errors = 0;

  veri_phase_comp_coarse_accum #(
    .WIDTH       (WIDTH),
    .RESET_VAL   (RESET_VAL),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk      (clk),
    .resetb   (resetb),
    .enable   (enable),
    .load_en  (load_en),
    .load_data(load_data),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .reg_out  (reg_out),
    .busy     (busy),
    .wrap     (wrap),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  // Model: the code as an integer and the number of blank cycles still to run.
  int m_code = RESET_VAL;
  int m_left = 0;
  bit m_wrap = 1'b0;
  bit m_drop = 1'b0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_code <= RESET_VAL;
      m_left <= 0;
      m_wrap <= 1'b0;
      m_drop <= 1'b0;
    end else begin
      automatic bit is_up = step_up && !step_dn;
      automatic bit is_dn = step_dn && !step_up;
      automatic int nxt = is_up ? m_code + 1 : m_code - 1;
      m_wrap <= 1'b0;
      m_drop <= 1'b0;
      if (enable) begin
        if (load_en) begin
          m_code <= int'(load_data);
          m_left <= 0;
        end else if (m_left > 0) begin
          m_drop <= is_up || is_dn;
          m_left <= m_left - 1;
        end else if (is_up || is_dn) begin
`ifdef COARSE_ACCUM_SAT_EN
          if (nxt >= 0 && nxt <= MAXV) begin
            m_code <= nxt;
            m_left <= BLANK_CYCLES;
          end
`else
          m_code <= (nxt + MAXV + 1) % (MAXV + 1);
          m_left <= BLANK_CYCLES;
          m_wrap <= (nxt < 0) || (nxt > MAXV) || (WIDTH == 1);
`endif
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_reg_out", int'(reg_out), m_code);
    check("model_busy", int'(busy), int'(m_left > 0));
    check("model_wrap", int'(wrap), int'(m_wrap));
    check("model_dropped", int'(dropped), int'(m_drop));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit en, input bit ld, input int ldv, input bit up, input bit dn);
    enable    = en;
    load_en   = ld;
    load_data = WIDTH'(ldv);
    step_up   = up;
    step_dn   = dn;
  endtask

  task automatic idle(input int n);
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tick();
    tick();
    check("reset_reg_out", int'(reg_out), 1);
    check("reset_busy", int'(busy), 0);
    resetb = 1'b1;
    idle(1);

    // Single step and blank window length.
    set_in(1, 0, 0, 1, 0);
    tick();
    check("step_reg_out", int'(reg_out), 2);
    check("step_busy", int'(busy), 1);
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blank_busy", int'(busy), 1);
    end
    tick();
    check("blank_end_busy", int'(busy), 0);

`ifndef COARSE_ACCUM_SAT_EN
    // Wrap in both directions.
    set_in(1, 1, 3, 0, 0);
    tick();
    check("load_reg_out", int'(reg_out), 3);
    set_in(1, 0, 0, 1, 0);
    tick();
    check("wrap_up_reg_out", int'(reg_out), 0);
    check("wrap_up_pulse", int'(wrap), 1);
    idle(1);
    check("wrap_pulse_clear", int'(wrap), 0);
    idle(3);
    set_in(1, 0, 0, 0, 1);
    tick();
    check("wrap_dn_reg_out", int'(reg_out), 3);
    check("wrap_dn_pulse", int'(wrap), 1);
    idle(4);
`endif

    // Blanking: steps at cycles 0, 2 and 5.
    set_in(1, 1, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 1, 0);
    tick();
    check("blank_first_step", int'(reg_out), 2);
    idle(1);
    set_in(1, 0, 0, 1, 0);
    tick();
    check("blank_dropped", int'(dropped), 1);
    check("blank_no_change", int'(reg_out), 2);
    idle(2);
    set_in(1, 0, 0, 1, 0);
    tick();
    check("blank_second_accept", int'(reg_out), RESET_VAL + 2);

    // Load beats step while blanking.
    set_in(1, 1, 2, 0, 1);
    tick();
    check("prio_reg_out", int'(reg_out), 2);
    check("prio_busy", int'(busy), 0);
    check("prio_dropped", int'(dropped), 0);

    // Enable low and simultaneous requests are no-ops.
    set_in(0, 0, 0, 1, 0);
    tick();
    check("disable_reg_out", int'(reg_out), 2);
    set_in(1, 0, 0, 1, 1);
    tick();
    check("both_reg_out", int'(reg_out), 2);
    check("both_busy", int'(busy), 0);
    check("both_dropped", int'(dropped), 0);

    // Asynchronous reset mid-blank.
    set_in(1, 0, 0, 1, 0);
    tick();
    set_in(1, 0, 0, 0, 0);
    #2;
    resetb = 1'b0;
    #1;
    check("async_reset_reg_out", int'(reg_out), RESET_VAL);
    check("async_reset_busy", int'(busy), 0);
    tick();
    resetb = 1'b1;

    // Randomized traffic, checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) != 0,
             $urandom_range(0, 19) == 0,
             int'($urandom_range(0, MAXV)),
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0);
      if (i == 1500) begin
        #2;
        resetb = 1'b0;
        #2;
        resetb = 1'b1;
      end
      tick();
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
